// File: rtl/la_phasegen2.sv
// Two-phase non-overlapping latch-enable generator.
// Phase and gap lengths are sampled once per period and clamped to at least one cycle.
module la_phasegen2 #(
    parameter string       PROP = "DEFAULT",
    parameter int unsigned CW   = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          en,
    input  logic [CW-1:0] hi_len,
    input  logic [CW-1:0] gap_len,
    output logic          ph1,
    output logic          ph2,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        StIdle,
        StPh1,
        StGap1,
        StPh2,
        StGap2
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] hi_q;
    logic [CW-1:0] gap_q;

    // Counter reload value: a zero length behaves like a length of one.
    function automatic logic [CW-1:0] len_m1(input logic [CW-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            gap_q   <= '0;
            ph1     <= 1'b0;
            ph2     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (en) begin
                        state_q <= StPh1;
                        hi_q    <= hi_len;
                        gap_q   <= gap_len;
                        cnt_q   <= len_m1(hi_len);
                        ph1     <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                StPh1: begin
                    if (cnt_q == '0) begin
                        state_q <= StGap1;
                        cnt_q   <= len_m1(gap_q);
                        ph1     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StGap1: begin
                    if (cnt_q == '0) begin
                        state_q <= StPh2;
                        cnt_q   <= len_m1(hi_q);
                        ph2     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StPh2: begin
                    if (cnt_q == '0) begin
                        state_q <= StGap2;
                        cnt_q   <= len_m1(gap_q);
                        ph2     <= 1'b0;
                        // A one-cycle gap makes the first GAP2 cycle also the last one.
                        done    <= (len_m1(gap_q) == '0);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StGap2: begin
                    if (cnt_q == '0) begin
                        if (en) begin
                            state_q <= StPh1;
                            hi_q    <= hi_len;
                            gap_q   <= gap_len;
                            cnt_q   <= len_m1(hi_len);
                            ph1     <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        done  <= (cnt_q == CW'(1));
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    ph1     <= 1'b0;
                    ph2     <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_la_phasegen2.sv
// Scoreboard bench for la_phasegen2: a period-level model queues expected outputs per cycle,
// and an independent monitor compares them and checks the non-overlap invariants.
module tb_la_phasegen2;

    localparam int CW = 4;

    // Expected-output encoding: {ph1, ph2, busy, done}
    localparam logic [3:0] OutIdle = 4'b0000;
    localparam logic [3:0] OutPh1  = 4'b1010;
    localparam logic [3:0] OutGap  = 4'b0010;
    localparam logic [3:0] OutPh2  = 4'b0110;
    localparam logic [3:0] OutDone = 4'b0011;

    logic          clk     = 1'b0;
    logic          nreset  = 1'b1;
    logic          en      = 1'b0;
    logic [CW-1:0] hi_len  = '0;
    logic [CW-1:0] gap_len = '0;
    logic          ph1;
    logic          ph2;
    logic          busy;
    logic          done;

    la_phasegen2 #(
        .PROP ("DEFAULT"),
        .CW   (CW)
    ) dut (
        .clk     (clk),
        .nreset  (nreset),
        .en      (en),
        .hi_len  (hi_len),
        .gap_len (gap_len),
        .ph1     (ph1),
        .ph2     (ph2),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    int         done_cnt = 0;
    int         cyc      = 0;
    logic [3:0] plan[$];
    logic [3:0] exp_q[$];
    logic [3:0] exp_v;
    logic [3:0] act_v;
    logic       prev_ph1 = 1'b0;
    logic       prev_ph2 = 1'b0;
    bit         found;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    function automatic int eff(input logic [CW-1:0] len);
        return (len == '0) ? 1 : int'(len);
    endfunction

    // One whole period as a flat list of cycles.
    task automatic push_period(input int h, input int g);
        for (int i = 0; i < h; i++) plan.push_back(OutPh1);
        for (int i = 0; i < g; i++) plan.push_back(OutGap);
        for (int i = 0; i < h; i++) plan.push_back(OutPh2);
        for (int i = 0; i < g - 1; i++) plan.push_back(OutGap);
        plan.push_back(OutDone);
    endtask

    // Called with the inputs that the coming rising edge will sample.
    task automatic model_step();
        if (plan.size() == 0) begin
            if (en) push_period(eff(hi_len), eff(gap_len));
            else plan.push_back(OutIdle);
        end
        exp_q.push_back(plan.pop_front());
    endtask

    task automatic step(input logic e, input int h, input int g);
        @(negedge clk);
        en      = e;
        hi_len  = CW'(h);
        gap_len = CW'(g);
        model_step();
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #2;
        nreset = 1'b0;
        #1;
        check("async_reset_outputs", {28'd0, ph1, ph2, busy, done}, 32'd0);
        plan.delete();
        exp_q.delete();
    endtask

    task automatic release_reset(input logic e);
        repeat (2) @(negedge clk);
        nreset  = 1'b1;
        en      = e;
        hi_len  = 4'd3;
        gap_len = 4'd1;
        model_step();
    endtask

    // Monitor: scoreboard pop plus invariant checks.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (nreset) begin
                if (exp_q.size() > 0) begin
                    exp_v = exp_q.pop_front();
                    act_v = {ph1, ph2, busy, done};
                    checks++;
                    if (act_v !== exp_v) begin
                        failures++;
                        $display("FAIL outputs cyc=%0d got=%b want=%b (ph1 ph2 busy done)",
                                 cyc, act_v, exp_v);
                    end
                end
                checks++;
                if ((ph1 && ph2) || (ph2 && !prev_ph2 && prev_ph1) ||
                    (ph1 && !prev_ph1 && prev_ph2)) begin
                    failures++;
                    $display("FAIL non_overlap cyc=%0d got ph1=%b ph2=%b prev ph1=%b ph2=%b",
                             cyc, ph1, ph2, prev_ph1, prev_ph2);
                end
                if (done) done_cnt++;
                prev_ph1 = ph1;
                prev_ph2 = ph2;
            end else begin
                prev_ph1 = 1'b0;
                prev_ph2 = 1'b0;
            end
        end
    end

    initial begin
        #1 nreset = 1'b0;
        #1;
        check("reset_state", {28'd0, ph1, ph2, busy, done}, 32'd0);
        release_reset(1'b0);

        // Basic timing: hi=2, gap=1
        repeat (14) step(1'b1, 2, 1);

        // Zero lengths clamp to a 4-cycle period
        assert_reset();
        release_reset(1'b0);
        done_cnt = 0;
        repeat (20) step(1'b1, 0, 0);
        @(posedge clk);
        #2;
        check("zero_len_done_count", done_cnt, 5);

        // Single-cycle request gives exactly one period
        assert_reset();
        release_reset(1'b0);
        done_cnt = 0;
        step(1'b1, 3, 2);
        repeat (14) step(1'b0, $urandom_range(0, 15), $urandom_range(0, 15));
        @(posedge clk);
        #2;
        check("single_req_done_count", done_cnt, 1);
        check("single_req_idle_busy", {31'd0, busy}, 32'd0);

        // Length change during GAP1 applies from the next period
        assert_reset();
        release_reset(1'b0);
        repeat (3) step(1'b1, 2, 2);
        repeat (24) step(1'b1, 5, 2);

        // Reset asserted during PH2
        assert_reset();
        release_reset(1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 3, 1);
            @(posedge clk);
            #2;
            if (ph2) found = 1'b1;
        end
        check("reach_ph2_within_bound", {31'd0, found}, 32'd1);
        nreset = 1'b0;
        #1;
        check("mid_reset_ph2_low", {31'd0, ph2}, 32'd0);
        check("mid_reset_busy_low", {31'd0, busy}, 32'd0);
        plan.delete();
        exp_q.delete();
        release_reset(1'b1);
        repeat (12) step(1'b1, 3, 1);

        // Random stress
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                assert_reset();
                release_reset(1'($urandom_range(0, 1)));
            end else begin
                step(1'($urandom_range(0, 3) != 0), $urandom_range(0, 15),
                     $urandom_range(0, 15));
            end
        end

        @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        failures++;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/la_phasegen2.md
LA_PHASEGEN2 -- requirements
Module: la_phasegen2

Interface
REQ-001 Parameter: PROP, "DEFAULT", implementation property string, carried through without functional effect.
REQ-002 Parameter: CW, 4, width of the phase-length and gap-length inputs and of the internal counter.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: nreset  input  1  asynchronous active-low reset.
REQ-005 Port: en  input  1  run request; sampled every cycle.
REQ-006 Port: hi_len  input  CW  active length of each phase, in clk cycles.
REQ-007 Port: gap_len  input  CW  non-overlap gap after each phase, in clk cycles.
REQ-008 Port: ph1  output  1  phase-1 latch enable (drives active-high transparent latches).
REQ-009 Port: ph2  output  1  phase-2 latch enable.
REQ-010 Port: busy  output  1  high whenever the FSM is not IDLE.
REQ-011 Port: done  output  1  one-cycle pulse on the final cycle of each completed period.

Function
REQ-012 FSM states: IDLE, PH1, GAP1, PH2, GAP2.
REQ-013 ph1, ph2, busy and done are registered; no combinational path from any input to any output.
REQ-014 IDLE -> PH1 when en=1 at a rising edge; ph1 is high in the cycle after en is sampled high.
REQ-015 Effective phase length is max(hi_len,1); effective gap length is max(gap_len,1).
REQ-016 hi_len and gap_len are captured into shadow registers on each IDLE->PH1 or GAP2->PH1 transition; input changes mid-period take effect only from the next period.
REQ-017 Sequence: PH1 (ph1=1) for the phase length, GAP1 (both low) for the gap length, PH2 (ph2=1) for the phase length, then GAP2 (both low) for the gap length.
REQ-018 Period = 2*(phase length + gap length) cycles.
REQ-019 Down-counter loads length-1 on each state entry; the state advances when the counter reaches 0.
REQ-020 done=1 exactly during the last GAP2 cycle and is 0 in all other cycles.
REQ-021 At the end of GAP2: go to PH1 if en=1, else go to IDLE.
REQ-022 Deasserting en mid-period does not abort; the current period completes through GAP2.
REQ-023 Invariant: ph1 and ph2 are never high in the same cycle.
REQ-024 Invariant: at least one cycle with both low separates every ph1 fall from the next ph2 rise, and every ph2 fall from the next ph1 rise.
REQ-025 busy=0 only in IDLE; in IDLE, ph1=ph2=done=0.

Reset
REQ-026 When nreset=0, the block immediately (asynchronously) forces state=IDLE, counter=0, shadow registers=0, and ph1=ph2=busy=done=0.
REQ-027 Reset release is sampled on a clk edge; the first PH1 occurs no earlier than one cycle after en is sampled high following release.
REQ-028 Reset asserted mid-period discards the period; no partial phase resumes after release.

Structure
REQ-029 No shared package; state encoding and length-clamp logic are local constants of this module.
REQ-030 A single flat module; no sub-module is natural (the counter and FSM are tightly coupled).

Verification
REQ-031 Basic timing: hi_len=2, gap_len=1, en held high from cycle 0 -> ph1 high in cycles 1-2, gap in cycle 3, ph2 high in cycles 4-5, cycle 6 both low with done=1, ph1 high again in cycle 7.
REQ-032 Zero-length clamping: hi_len=0, gap_len=0, en held -> period of 4 cycles (ph1, gap, ph2, gap); done every 4th cycle.
REQ-033 Single-cycle request: en pulsed for one cycle, hi_len=3, gap_len=2 -> exactly one 10-cycle period, one done pulse, then busy=0 and outputs low.
REQ-034 Mid-period length change: hi_len changed from 2 to 5 during GAP1 -> current PH2 lasts 2 cycles; the next PH1 lasts 5 cycles.
REQ-035 Mid-period reset: nreset driven low during PH2 -> ph2=0 and busy=0 before the next clk edge; after release with en=1, a full PH1 restarts one cycle later.
REQ-036 Random stress: 10k cycles of random en, hi_len and gap_len -> checker confirms REQ-023 and REQ-024 hold, and that every done is preceded by complete PH1 and PH2 phases.
